// File: rtl/ddr_burst_seq.sv
// Burst sequencer between a simple strike/beat source and a MIG-style app interface.
// One strike issues cycle_num+1 commands and data beats from a held base beat address.
module ddr_burst_seq #(
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned AW        = 28
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          init_calib_complete,
  input  logic [23:0]   mem_addr_i,
  input  logic [19:0]   cycle_num,
  input  logic          mem_wen_strike_i,
  input  logic          mem_ren_strike_i,
  input  logic [127:0]  mem_wdf_data_i,
  output logic          wdf_ack,
  output logic [127:0]  mem_rd_data_o,
  output logic          mem_rd_data_valid_o,
  output logic          wr_done_o,
  output logic          rd_done_o,
  output logic          busy,
  output logic [AW-1:0] app_addr,
  output logic [2:0]    app_cmd,
  output logic          app_en,
  input  logic          app_rdy,
  output logic [127:0]  app_wdf_data,
  output logic          app_wdf_wren,
  output logic          app_wdf_end,
  input  logic          app_wdf_rdy,
  input  logic [127:0]  app_rd_data,
  input  logic          app_rd_data_valid
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  state_e         state_q, state_d;
  logic [20:0]    cmd_cnt_q, cmd_cnt_d;
  logic [20:0]    dat_cnt_q, dat_cnt_d;
  logic [23:0]    base_q, base_d;
  logic [19:0]    last_q, last_d;
  logic           wr_done_q, wr_done_d;
  logic           rd_done_q, rd_done_d;
  logic           rd_vld_q, rd_vld_d;
  logic [127:0]   rd_data_q, rd_data_d;

  logic [20:0]    last_ext;
  logic           wr_start, rd_start;
  logic           cmd_live, dat_live, cmd_fire;
  logic [47:0]    addr_full;

  assign last_ext = {1'b0, last_q};
  assign wr_start = (state_q == IDLE) && init_calib_complete && mem_wen_strike_i;
  assign rd_start = (state_q == IDLE) && init_calib_complete && mem_ren_strike_i && !mem_wen_strike_i;

  // Counters are one bit wider than cycle_num so 2^20 beats finish without wrapping.
  assign addr_full = {24'd0, base_q} + 48'(cmd_cnt_q) * 48'(ADDR_STEP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
      base_q    <= '0;
      last_q    <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_cnt_q <= cmd_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      base_q    <= base_d;
      last_q    <= last_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    base_d    = base_q;
    last_d    = last_q;
    wr_done_d = wr_done_q;
    rd_done_d = rd_done_q;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (wr_start || rd_start) begin
          cmd_cnt_d = '0;
          dat_cnt_d = '0;
          base_d    = mem_addr_i;
          last_d    = cycle_num;
        end
        if (wr_start) begin
          state_d   = WR;
          wr_done_d = 1'b0;
        end else if (rd_start) begin
          state_d   = RD;
          rd_done_d = 1'b0;
        end
      end
      WR: begin
        if (cmd_fire) cmd_cnt_d = cmd_cnt_q + 21'd1;
        if (wdf_ack)  dat_cnt_d = dat_cnt_q + 21'd1;
        // Leave on the edge that completes whichever stream finishes last.
        if ((cmd_cnt_d > last_ext) && (dat_cnt_d > last_ext)) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
      end
      RD: begin
        if (cmd_fire) cmd_cnt_d = cmd_cnt_q + 21'd1;
        if (app_rd_data_valid) begin
          rd_vld_d  = 1'b1;
          rd_data_d = app_rd_data;
          dat_cnt_d = dat_cnt_q + 21'd1;
          if (dat_cnt_q == last_ext) begin
            state_d   = IDLE;
            rd_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_live     = (state_q != IDLE) && (cmd_cnt_q <= last_ext);
    dat_live     = (state_q == WR) && (dat_cnt_q <= last_ext);
    cmd_fire     = cmd_live && app_rdy;
    app_en       = cmd_live;
    app_cmd      = (state_q == RD) ? 3'd1 : 3'd0;
    app_wdf_wren = dat_live;
    app_wdf_end  = dat_live;
    wdf_ack      = dat_live && app_wdf_rdy;
    busy         = (state_q != IDLE);
  end

  assign app_addr            = addr_full[AW-1:0];
  assign app_wdf_data        = mem_wdf_data_i;
  assign mem_rd_data_o       = rd_data_q;
  assign mem_rd_data_valid_o = rd_vld_q;
  assign wr_done_o           = wr_done_q;
  assign rd_done_o           = rd_done_q;

endmodule

// File: tb/tb_ddr_burst_seq.sv
// Scoreboard bench for ddr_burst_seq: stimulus queues expected commands/beats,
// a MIG-like bus model stores and returns data, a monitor pops and compares.
module tb_ddr_burst_seq;

  logic         clk = 1'b0;
  logic         rstn;
  logic         init_calib_complete;
  logic [23:0]  mem_addr_i;
  logic [19:0]  cycle_num;
  logic         mem_wen_strike_i;
  logic         mem_ren_strike_i;
  logic [127:0] mem_wdf_data_i;
  logic         wdf_ack;
  logic [127:0] mem_rd_data_o;
  logic         mem_rd_data_valid_o;
  logic         wr_done_o;
  logic         rd_done_o;
  logic         busy;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  always #5 clk = ~clk;

  ddr_burst_seq #(.ADDR_STEP(8), .AW(28)) dut (
    .clk(clk), .rstn(rstn), .init_calib_complete(init_calib_complete),
    .mem_addr_i(mem_addr_i), .cycle_num(cycle_num),
    .mem_wen_strike_i(mem_wen_strike_i), .mem_ren_strike_i(mem_ren_strike_i),
    .mem_wdf_data_i(mem_wdf_data_i), .wdf_ack(wdf_ack),
    .mem_rd_data_o(mem_rd_data_o), .mem_rd_data_valid_o(mem_rd_data_valid_o),
    .wr_done_o(wr_done_o), .rd_done_o(rd_done_o), .busy(busy),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  typedef struct { logic [27:0] addr; logic [2:0] cmd; } cmd_t;
  typedef struct { int unsigned due; logic [127:0] data; } ret_t;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  cmd_t         exp_cmd_q[$];
  logic [127:0] exp_wd_q[$];
  logic [127:0] exp_rd_q[$];
  logic [127:0] refmem[logic [27:0]];
  logic         exp_wr_done = 1'b0;
  logic         exp_rd_done = 1'b0;

  int unsigned  rdy_mode = 0;
  logic [127:0] src_q[$];

  logic [27:0]  wa_q[$];
  logic [127:0] wd_q[$];
  ret_t         rp_q[$];
  logic [127:0] mig[logic [27:0]];
  int unsigned  src_idx = 0;
  int unsigned  blk = 0;
  int unsigned  cyc_n = 0;
  int unsigned  n_dat_hs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_get(input logic [27:0] a);
    return refmem.exists(a) ? refmem[a] : '0;
  endfunction

  function automatic logic [127:0] mig_get(input logic [27:0] a);
    return mig.exists(a) ? mig[a] : '0;
  endfunction

  // MIG-like bus model and write-data source
  always begin
    logic s_dat, s_new;
    ret_t r;
    @(negedge clk);
    s_dat = wdf_ack;
    s_new = (mem_wen_strike_i || mem_ren_strike_i) && !busy;
    if (app_en && app_rdy) begin
      if (app_cmd == 3'd0) wa_q.push_back(app_addr);
      else rp_q.push_back('{due: cyc_n + 2, data: mig_get(app_addr)});
    end
    if (wdf_ack) begin
      wd_q.push_back(app_wdf_data);
      n_dat_hs++;
    end
    while (wa_q.size() > 0 && wd_q.size() > 0) mig[wa_q.pop_front()] = wd_q.pop_front();
    @(posedge clk);
    cyc_n++;
    #1;
    if (!rstn) begin
      wa_q.delete(); wd_q.delete(); rp_q.delete();
      src_idx = 0;
    end else if (s_new) begin
      src_idx = 0;
      blk = 5;
    end else if (s_dat) begin
      src_idx++;
    end
    app_rdy     = (rdy_mode == 2) ? (blk == 0) : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b1;
    app_wdf_rdy = (rdy_mode == 2) ? !app_wdf_rdy : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b1;
    if (blk > 0) blk--;
    mem_wdf_data_i = (src_idx < src_q.size()) ? src_q[src_idx] : '0;
    if (rp_q.size() > 0 && rp_q[0].due <= cyc_n) begin
      r = rp_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = r.data;
    end else if (!busy && ($urandom % 3 == 0)) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer
  always @(negedge clk) begin
    cmd_t e;
    logic [127:0] d;
    if (rstn) begin
      if (app_en && app_rdy) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd_extra: got command at addr %0h, required none outstanding", app_addr);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_addr", 128'(app_addr), 128'(e.addr));
          chk("cmd_type", 128'(app_cmd), 128'(e.cmd));
        end
      end
      if (wdf_ack) begin
        chk("ack_needs_rdy", 128'(app_wdf_rdy), 128'(1));
        if (exp_wd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wdata_extra: got beat %0h, required none outstanding", app_wdf_data);
        end else begin
          d = exp_wd_q.pop_front();
          chk("wdata", app_wdf_data, d);
        end
      end
      if (mem_rd_data_valid_o) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rdata_extra: got valid beat %0h, required none outstanding", mem_rd_data_o);
        end else begin
          d = exp_rd_q.pop_front();
          chk("rdata", mem_rd_data_o, d);
          chk("rd_done_with_last", 128'(rd_done_o), 128'(exp_rd_q.size() == 0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int unsigned budget);
    bit ok = 1'b0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", nm, budget);
    end
    step();
  endtask

  task automatic load_write(input logic [23:0] base, input int unsigned cn, input bit upd);
    logic [127:0] d;
    logic [27:0]  a;
    src_q.delete();
    for (int unsigned i = 0; i <= cn; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      a = 28'(base) + 28'(i * 8);
      src_q.push_back(d);
      exp_cmd_q.push_back('{addr: a, cmd: 3'd0});
      exp_wd_q.push_back(d);
      if (upd) refmem[a] = d;
    end
    mem_addr_i = base;
    cycle_num  = 20'(cn);
  endtask

  // extra: 0 plain, 1 both strikes together, 2 strikes again while busy
  task automatic do_write(input logic [23:0] base, input int unsigned cn,
                          input int unsigned mode, input int unsigned extra);
    load_write(base, cn, 1'b1);
    rdy_mode = mode;
    mem_wen_strike_i = 1'b1;
    mem_ren_strike_i = (extra == 1);
    step();
    mem_wen_strike_i = 1'b0;
    mem_ren_strike_i = 1'b0;
    @(negedge clk);
    chk("wr_busy", 128'(busy), 128'(1));
    chk("wr_done_cleared", 128'(wr_done_o), 128'(0));
    step();
    if (extra == 2) begin
      mem_addr_i = 24'($urandom);
      cycle_num  = 20'($urandom);
      mem_wen_strike_i = 1'b1;
      mem_ren_strike_i = 1'b1;
      step();
      mem_wen_strike_i = 1'b0;
      mem_ren_strike_i = 1'b0;
    end
    wait_idle("wr", 30 * (cn + 1) + 40);
    exp_wr_done = 1'b1;
    chk("wr_done", 128'(wr_done_o), 128'(1));
    chk("rd_done_kept", 128'(rd_done_o), 128'(exp_rd_done));
    chk("wr_cmds_left", 128'(exp_cmd_q.size()), 128'(0));
    chk("wr_beats_left", 128'(exp_wd_q.size()), 128'(0));
    chk("idle_app_en", 128'(app_en), 128'(0));
    chk("idle_wren", 128'(app_wdf_wren), 128'(0));
  endtask

  task automatic do_read(input logic [23:0] base, input int unsigned cn, input int unsigned mode);
    logic [27:0] a;
    for (int unsigned i = 0; i <= cn; i++) begin
      a = 28'(base) + 28'(i * 8);
      exp_cmd_q.push_back('{addr: a, cmd: 3'd1});
      exp_rd_q.push_back(ref_get(a));
    end
    mem_addr_i = base;
    cycle_num  = 20'(cn);
    rdy_mode   = mode;
    mem_ren_strike_i = 1'b1;
    step();
    mem_ren_strike_i = 1'b0;
    @(negedge clk);
    chk("rd_busy", 128'(busy), 128'(1));
    chk("rd_done_cleared", 128'(rd_done_o), 128'(0));
    step();
    wait_idle("rd", 30 * (cn + 1) + 40);
    exp_rd_done = 1'b1;
    chk("rd_done", 128'(rd_done_o), 128'(1));
    chk("wr_done_kept", 128'(wr_done_o), 128'(exp_wr_done));
    chk("rd_cmds_left", 128'(exp_cmd_q.size()), 128'(0));
    chk("rd_beats_left", 128'(exp_rd_q.size()), 128'(0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0]  base;
    int unsigned  cn, cn2, n0;
    bit           hit;
    rstn = 1'b0;
    init_calib_complete = 1'b0;
    mem_addr_i = '0;
    cycle_num = '0;
    mem_wen_strike_i = 1'b0;
    mem_ren_strike_i = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    mem_wdf_data_i = '0;
    repeat (3) step();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_app_addr", 128'(app_addr), 128'(0));
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_rd_data", mem_rd_data_o, '0);
    chk("rst_rd_valid", 128'(mem_rd_data_valid_o), 128'(0));
    chk("rst_dones", 128'({wr_done_o, rd_done_o}), 128'(0));
    rstn = 1'b1;
    step();

    // calibration not complete: strike ignored
    mem_wen_strike_i = 1'b1;
    step();
    mem_wen_strike_i = 1'b0;
    @(negedge clk);
    chk("nocal_busy", 128'(busy), 128'(0));
    step();
    init_calib_complete = 1'b1;
    step();

    do_write(24'h000000, 3, 0, 0);
    do_read(24'h000000, 3, 0);
    do_write(24'h012340, 9, 2, 0);
    do_read(24'h012340, 9, 2);
    do_write(24'h0A0000, 5, 0, 1);
    do_write(24'h0B0000, 6, 0, 2);
    do_read(24'h0B0000, 6, 1);

    for (int unsigned it = 0; it < 6; it++) begin
      base = 24'($urandom % 24'hE00000);
      cn   = $urandom_range(0, 12);
      cn2  = $urandom_range(0, cn);
      do_write(base, cn, $urandom_range(0, 2), 0);
      do_read(base, cn2, $urandom_range(0, 2));
    end

    // asynchronous reset in the middle of a write
    load_write(24'hF00000, 7, 1'b0);
    rdy_mode = 0;
    n0 = n_dat_hs;
    mem_wen_strike_i = 1'b1;
    step();
    mem_wen_strike_i = 1'b0;
    hit = 1'b0;
    for (int unsigned k = 0; k < 50; k++) begin
      @(negedge clk);
      if (n_dat_hs >= n0 + 2) begin hit = 1'b1; break; end
    end
    chk("rst_reached_beat2", 128'(hit), 128'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_app_en", 128'(app_en), 128'(0));
    chk("arst_wren", 128'({app_wdf_wren, app_wdf_end, wdf_ack}), 128'(0));
    chk("arst_app_addr", 128'(app_addr), 128'(0));
    chk("arst_app_cmd", 128'(app_cmd), 128'(0));
    chk("arst_rd_data", mem_rd_data_o, '0);
    chk("arst_rd_valid", 128'(mem_rd_data_valid_o), 128'(0));
    chk("arst_dones", 128'({wr_done_o, rd_done_o}), 128'(0));
    exp_cmd_q.delete();
    exp_wd_q.delete();
    exp_rd_q.delete();
    exp_wr_done = 1'b0;
    exp_rd_done = 1'b0;
    step();
    mem_wen_strike_i = 1'b1;
    step();
    mem_wen_strike_i = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("no_strike_in_reset", 128'(busy), 128'(0));
    step();
    do_write(24'h000100, 0, 0, 0);
    do_read(24'h000100, 0, 1);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
